if_inst_queue: RTL and testbench
================================

Name: if_inst_queue

Overview:
- Instruction fetch queue directly downstream of the PC register / instruction ROM pair.
- Captures each fetched {pc, inst} pair and buffers up to DEPTH entries.
- Presents the oldest entry to the IF/ID boundary with a valid/ready handshake.
- Back-pressures the PC register via fetch_stall when full. Discards all buffered entries on a redirect (branch/jump flush).

Parameters:
- DEPTH, 4, number of entries; power of 2, minimum 2.
- PTR_W, 2, log2(DEPTH); pointer width.
- ADDR_W, 32, instruction address width (matches InstAddrBus).
- DATA_W, 32, instruction word width (matches InstBus).

Ports:
- clk  input  1  system clock, all state updates on rising edge
- rst  input  1  synchronous reset, active-high; sampled on rising edge of clk
- in_valid  input  1  fetch side presents a valid {in_pc, in_inst} this cycle (driven from PC-register ce)
- in_pc  input  ADDR_W  address of fetched instruction
- in_inst  input  DATA_W  fetched instruction word
- in_ready  output  1  queue can accept a push this cycle
- fetch_stall  output  1  = ~in_ready; PC register holds pc when high
- out_valid  output  1  head entry valid
- out_pc  output  ADDR_W  head entry address
- out_inst  output  DATA_W  head entry instruction
- out_ready  input  1  ID stage accepts head this cycle (deasserted on ID stall)
- flush  input  1  redirect: discard all entries
- count  output  PTR_W+1  current occupancy, 0..DEPTH

Behaviour:
- Reset (rst=1 at rising edge):
  - wr_ptr=0, rd_ptr=0, count=0.
  - out_valid=0, out_pc=0, out_inst=0 (ZeroWord/NOP), in_ready=1, fetch_stall=0.
  - Storage contents are don't-care.
- Push: in_valid & in_ready at an edge.
  - Writes mem[wr_ptr] = {in_pc, in_inst}.
  - wr_ptr increments modulo DEPTH (natural wrap, PTR_W bits).
- Pop: out_valid & out_ready at an edge.
  - rd_ptr increments modulo DEPTH.
- Occupancy:
  - count +1 on push only, -1 on pop only, unchanged on both or neither.
- Flags and outputs:
  - in_ready = (count != DEPTH).
  - out_valid = (count != 0).
  - out_pc/out_inst are read combinationally from mem[rd_ptr] (first-word-fall-through).
  - When out_valid=0, out_pc and out_inst are forced to 0.
- Latency: an entry pushed at edge N is visible on the outputs after edge N; pop at edge N+1 at the earliest.
- Full (count=DEPTH):
  - in_ready=0; a push is ignored even if a pop occurs in the same cycle.
  - in_ready rises the cycle after the pop.
  - No entry is overwritten.
- Empty (count=0): a pop is ignored, out_ready is don't-care, rd_ptr is unchanged.
- Simultaneous push and pop when 0<count<DEPTH: both pointers advance, count is unchanged.
- Flush=1 at an edge:
  - wr_ptr=rd_ptr=0, count=0.
  - A push and a pop in the same cycle are both discarded.
  - The next cycle gives out_valid=0 and in_ready=1.
  - Flush has priority over push and pop.
- Reset asserted mid-operation: identical to flush, plus outputs return to reset values; reset has priority over flush.
- Storage:
  - No combinational path from out_ready to in_ready (in_ready depends on registered count only).
  - Storage is DEPTH registers of ADDR_W+DATA_W bits, not inferred RAM with read latency.

Optional Feature:
- Macro: IFQ_BYPASS_EN.
- Defined: when count=0, in_valid=1 and flush=0:
  - out_valid=1 and out_pc/out_inst=in_pc/in_inst combinationally in the same cycle.
  - If out_ready=1, the entry is consumed without a write; pointers and count are unchanged.
  - If out_ready=0, the entry is pushed normally.
- Not defined: no bypass; minimum latency is one cycle as above.

Test Plan:
- Reset then idle: rst=1 for 2 cycles, then rst=0 with in_valid=0 -> count=0, out_valid=0, out_pc=0, out_inst=0, in_ready=1.
- Stream through: push pc=0x0,0x4,0x8 (inst 0x34011100,0x34020020,0x3403ff00) with out_ready=1 -> outputs appear in order one cycle after each push, count never exceeds 1.
- Fill and stall: out_ready=0, push 5 pcs 0x0..0x10 -> after 4 pushes count=4, fetch_stall=1, 5th push (pc 0x10) not accepted. Then one pop -> out_pc=0x4 next, in_ready=1.
- Wrap-around: 10 push/pop pairs with DEPTH=4 interleaved at count=2 -> pc sequence 0x0..0x24 emitted in order with no loss or duplication.
- Flush: count=3 (pcs 0x0,0x4,0x8), assert flush with in_valid=1 pc=0xC, out_ready=1 -> next cycle count=0, out_valid=0, pc 0xC absent. A subsequent push of pc=0x100 emerges first.
- Bypass (IFQ_BYPASS_EN defined): empty queue, in_valid=1 pc=0x20, out_ready=1 -> out_valid=1, out_pc=0x20 in the same cycle and count stays 0. Without the macro -> out_valid=0 that cycle and out_pc=0x20 the next cycle.

Source files
------------

// File: rtl/if_inst_queue.sv
// ---------------------------------------------------------------------------
// if_inst_queue
//
// Instruction fetch queue between the PC register / instruction ROM pair and
// the IF/ID boundary. Each fetched {pc, inst} pair is captured into a small
// register-based FIFO. The oldest entry is presented first-word-fall-through
// with a valid/ready handshake. The PC register is back-pressured through
// fetch_stall while the queue is full. A redirect (flush) discards every
// buffered entry.
//
// Optional build macro:
//   IFQ_BYPASS_EN - when the queue is empty, an incoming fetch is presented
//                   on the outputs in the same cycle. If ID accepts it, the
//                   entry is consumed without being written.
//
// Ports:
//   clk         in   system clock, all state changes on rising edge
//   rst         in   synchronous active-high reset
//   in_valid    in   fetch side presents {in_pc, in_inst} this cycle
//   in_pc       in   address of fetched instruction
//   in_inst     in   fetched instruction word
//   in_ready    out  queue can accept a push this cycle
//   fetch_stall out  inverse of in_ready; PC register holds when high
//   out_valid   out  head entry valid
//   out_pc      out  head entry address (0 when not valid)
//   out_inst    out  head entry instruction (0 when not valid)
//   out_ready   in   ID stage accepts the head this cycle
//   flush       in   redirect: discard all entries
//   count       out  current occupancy, 0..DEPTH
// ---------------------------------------------------------------------------
module if_inst_queue #(
  parameter int DEPTH  = 4,
  parameter int PTR_W  = 2,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [ADDR_W-1:0] in_pc,
  input  logic [DATA_W-1:0] in_inst,
  output logic              in_ready,
  output logic              fetch_stall,
  output logic              out_valid,
  output logic [ADDR_W-1:0] out_pc,
  output logic [DATA_W-1:0] out_inst,
  input  logic              out_ready,
  input  logic              flush,
  output logic [PTR_W:0]    count
);

  localparam logic [PTR_W:0]   LP_FULL    = (PTR_W+1)'(DEPTH);
  localparam logic [PTR_W:0]   LP_CNT_ONE = (PTR_W+1)'(1);
  localparam logic [PTR_W-1:0] LP_PTR_ONE = PTR_W'(1);

  logic [ADDR_W-1:0] r_memPc   [DEPTH];
  logic [DATA_W-1:0] r_memInst [DEPTH];
  logic [PTR_W-1:0]  r_wrPtr;
  logic [PTR_W-1:0]  r_rdPtr;
  logic [PTR_W:0]    r_count;

  logic w_empty;
  logic w_bypass;
  logic w_bypassTake;
  logic w_push;
  logic w_pop;

  // Flags depend only on the registered occupancy, so there is no
  // combinational path from out_ready to in_ready.
  assign w_empty     = (r_count == '0);
  assign in_ready    = (r_count != LP_FULL);
  assign fetch_stall = ~in_ready;
  assign count       = r_count;

`ifdef IFQ_BYPASS_EN
  // Empty queue with a live fetch: forward it straight to ID. If ID takes it
  // now, nothing is written and the queue state is left untouched.
  assign w_bypass     = w_empty & in_valid & ~flush;
  assign w_bypassTake = w_bypass & out_ready;
`else
  assign w_bypass     = 1'b0;
  assign w_bypassTake = 1'b0;
`endif

  // A push while full is ignored even if a pop happens in the same cycle;
  // flush discards both the push and the pop.
  assign w_push = in_valid & in_ready & ~flush & ~w_bypassTake;
  assign w_pop  = ~w_empty & out_ready & ~flush;

  // Head presentation: read straight out of the register file at rd_ptr,
  // forced to zero (NOP) whenever there is nothing valid to show.
  always_comb begin
    out_valid = ~w_empty;
    out_pc    = '0;
    out_inst  = '0;
    if (w_bypass) begin
      out_valid = 1'b1;
      out_pc    = in_pc;
      out_inst  = in_inst;
    end else if (!w_empty) begin
      out_pc    = r_memPc[r_rdPtr];
      out_inst  = r_memInst[r_rdPtr];
    end
  end

  // Storage registers carry no reset; their contents are meaningless until
  // the occupancy count says an entry is live.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_memPc[r_wrPtr]   <= in_pc;
      r_memInst[r_wrPtr] <= in_inst;
    end
  end

  // Pointer and occupancy bookkeeping. Reset and flush both empty the queue;
  // pointers wrap naturally at DEPTH since DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wrPtr <= r_wrPtr + LP_PTR_ONE;
      if (w_pop)  r_rdPtr <= r_rdPtr + LP_PTR_ONE;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + LP_CNT_ONE;
        2'b01:   r_count <= r_count - LP_CNT_ONE;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: tb/tb_if_inst_queue.sv
// ---------------------------------------------------------------------------
// tb_if_inst_queue
//
// Self-checking bench for if_inst_queue. A queue of {pc, inst} entries acts
// as the reference: it is emptied on reset/flush, pops its head when ID
// accepts, and appends a fetch when there is room. Directed sequences follow
// the test plan, then a randomized phase exercises mixed traffic.
// ---------------------------------------------------------------------------
module tb_if_inst_queue;

  localparam int DEPTH  = 4;
  localparam int PTR_W  = 2;
  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;

  typedef struct packed {
    logic [ADDR_W-1:0] pc;
    logic [DATA_W-1:0] inst;
  } entry_t;

  logic              clk;
  logic              rst;
  logic              in_valid;
  logic [ADDR_W-1:0] in_pc;
  logic [DATA_W-1:0] in_inst;
  logic              in_ready;
  logic              fetch_stall;
  logic              out_valid;
  logic [ADDR_W-1:0] out_pc;
  logic [DATA_W-1:0] out_inst;
  logic              out_ready;
  logic              flush;
  logic [PTR_W:0]    count;

  int checks   = 0;
  int failures = 0;
  bit checkEn  = 0;

  entry_t            model[$];
  logic [ADDR_W-1:0] popLog[$];

  if_inst_queue #(
    .DEPTH(DEPTH), .PTR_W(PTR_W), .ADDR_W(ADDR_W), .DATA_W(DATA_W)
  ) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_pc(in_pc), .in_inst(in_inst),
    .in_ready(in_ready), .fetch_stall(fetch_stall),
    .out_valid(out_valid), .out_pc(out_pc), .out_inst(out_inst),
    .out_ready(out_ready), .flush(flush), .count(count)
  );

  // Free-running clock, 10 time units per period.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Drives one cycle of inputs after the falling edge, compares every output
  // against the reference queue, then advances the reference at the rising
  // edge using the same inputs.
  task automatic applyStimulus(input bit r, input bit iv, input logic [ADDR_W-1:0] pc,
                               input logic [DATA_W-1:0] inst, input bit ordy,
                               input bit fl);
    bit                expValid;
    logic [ADDR_W-1:0] expPc;
    logic [DATA_W-1:0] expInst;
    bit                takeBypass;
    bit                doPop;
    bit                doPush;
    int                sz;
    @(negedge clk);
    rst = r; in_valid = iv; in_pc = pc; in_inst = inst; out_ready = ordy; flush = fl;
    #1;
    sz         = model.size();
    expValid   = (sz != 0);
    expPc      = (sz != 0) ? model[0].pc : '0;
    expInst    = (sz != 0) ? model[0].inst : '0;
    takeBypass = 1'b0;
`ifdef IFQ_BYPASS_EN
    if (sz == 0 && iv && !fl) begin
      expValid   = 1'b1;
      expPc      = pc;
      expInst    = inst;
      takeBypass = ordy;
    end
`endif
    if (checkEn) begin
      checkOutput("count",       64'(count),       64'(sz));
      checkOutput("out_valid",   64'(out_valid),   64'(expValid));
      checkOutput("out_pc",      64'(out_pc),      64'(expPc));
      checkOutput("out_inst",    64'(out_inst),    64'(expInst));
      checkOutput("in_ready",    64'(in_ready),    64'(sz != DEPTH));
      checkOutput("fetch_stall", 64'(fetch_stall), 64'(sz == DEPTH));
      if (out_valid && ordy && !fl && !r) popLog.push_back(out_pc);
    end
    @(posedge clk);
    if (r || fl) begin
      model.delete();
    end else begin
      doPop  = (sz != 0) && ordy;
      doPush = iv && (sz != DEPTH) && !takeBypass;
      if (doPop)  void'(model.pop_front());
      if (doPush) model.push_back('{pc: pc, inst: inst});
    end
    checkEn = 1'b1;
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_pc = '0; in_inst = '0; out_ready = 1'b0; flush = 1'b0;

    // Reset then idle.
    applyStimulus(1, 0, 0, 0, 0, 0);
    applyStimulus(1, 0, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 1, 0);

    // Stream through with ID always ready.
    applyStimulus(0, 1, 32'h0, 32'h34011100, 1, 0);
    applyStimulus(0, 1, 32'h4, 32'h34020020, 1, 0);
    applyStimulus(0, 1, 32'h8, 32'h3403ff00, 1, 0);
    applyStimulus(0, 0, 0, 0, 1, 0);
    applyStimulus(0, 0, 0, 0, 1, 0);

    // Fill and stall: fifth push must be refused.
    for (int i = 0; i < 5; i++)
      applyStimulus(0, 1, 32'(4*i), 32'h1000 + 32'(i), 0, 0);
    #2;
    checkOutput("fill_count", 64'(count), 64'd4);
    checkOutput("fill_stall", 64'(fetch_stall), 64'd1);
    applyStimulus(0, 0, 0, 0, 1, 0);
    #2;
    checkOutput("fill_next_pc", 64'(out_pc), 64'h4);
    checkOutput("fill_ready", 64'(in_ready), 64'd1);
    applyStimulus(0, 0, 0, 0, 0, 1);

    // Wrap-around: prefill two, eight push/pop pairs, then drain.
    popLog.delete();
    applyStimulus(0, 1, 32'h0, 32'hA0, 0, 0);
    applyStimulus(0, 1, 32'h4, 32'hA1, 0, 0);
    for (int i = 2; i < 10; i++)
      applyStimulus(0, 1, 32'(4*i), 32'hA0 + 32'(i), 1, 0);
    applyStimulus(0, 0, 0, 0, 1, 0);
    applyStimulus(0, 0, 0, 0, 1, 0);
    applyStimulus(0, 0, 0, 0, 1, 0);
    checkOutput("wrap_pop_count", 64'(popLog.size()), 64'd10);
    for (int i = 0; i < popLog.size() && i < 10; i++)
      checkOutput($sformatf("wrap_pc%0d", i), 64'(popLog[i]), 64'(4*i));

    // Flush with a simultaneous push and pop.
    applyStimulus(0, 1, 32'h0, 32'hB0, 0, 0);
    applyStimulus(0, 1, 32'h4, 32'hB1, 0, 0);
    applyStimulus(0, 1, 32'h8, 32'hB2, 0, 0);
    applyStimulus(0, 1, 32'hC, 32'hB3, 1, 1);
    #2;
    checkOutput("flush_count", 64'(count), 64'd0);
    applyStimulus(0, 1, 32'h100, 32'hC0, 0, 0);
    #2;
    checkOutput("flush_first_pc", 64'(out_pc), 64'h100);
    applyStimulus(0, 0, 0, 0, 1, 0);
    applyStimulus(0, 0, 0, 0, 1, 0);

    // Empty queue, fetch with ID ready: bypass or one-cycle latency.
    applyStimulus(0, 1, 32'h20, 32'hD0, 1, 0);
    applyStimulus(0, 0, 0, 0, 1, 0);
    applyStimulus(0, 0, 0, 0, 1, 0);

    // Randomized mixed traffic, including occasional flush and reset.
    for (int n = 0; n < 3000; n++)
      applyStimulus(($urandom_range(0, 59) == 0), ($urandom_range(0, 3) != 0),
                    32'($urandom) & 32'hFFFF_FFFC, 32'($urandom),
                    ($urandom_range(0, 2) != 0), ($urandom_range(0, 24) == 0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
